// File: rtl/ps2_rx_ctrl_if.sv
// Scancode delivery bus between the PS/2 frame receiver and its consumer.
// rx_valid/rx_ack: rx_data is held while rx_valid=1; a cycle with rx_ack=1 and rx_valid=1 consumes it.
interface ps2_rx_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_err;
  logic       overrun;

  modport master (output rx_data, output rx_valid, output rx_err, output overrun, input rx_ack);
  modport slave  (input rx_data, input rx_valid, input rx_err, input overrun, output rx_ack);
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: sequences start/8 data/odd parity/stop frames on debounced
// clock falls and hands good bytes to a one-entry holding register.
module ps2_rx_ctrl #(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int TO_W           = 15
) (
  input  logic           clk25,
  input  logic           rst_n,
  input  logic           ps2_clk_db,
  input  logic           ps2_data,
  ps2_rx_ctrl_if.master  rx,
  output logic           busy,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  state_t          state, state_n;
  logic            sync1, sync2, clk_prev;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shreg, shreg_n;
  logic            acc, acc_n;
  logic            par_ok, par_ok_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic            fall, to_hit, frame_good, frame_err;

  assign fall      = clk_prev & ~ps2_clk_db;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    acc_n      = acc;
    par_ok_n   = par_ok;
    frame_good = 1'b0;
    frame_err  = 1'b0;
    // A fall in the same cycle beats the timeout.
    to_hit     = (state != IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    to_cnt_n   = (state == IDLE || fall || to_hit) ? '0 : to_cnt + TO_W'(1);
    case (state)
      IDLE: begin
        if (fall && !sync2) begin
          state_n   = DATA;
          bit_cnt_n = 3'd0;
          acc_n     = 1'b0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_n   = {sync2, shreg[7:1]};
          acc_n     = acc ^ sync2;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_ok_n = acc ^ sync2;
          state_n  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (par_ok && sync2) frame_good = 1'b1;
          else                 frame_err  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (to_hit) begin
      state_n   = IDLE;
      frame_err = 1'b1;
    end
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state       <= IDLE;
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      clk_prev    <= 1'b1;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      acc         <= 1'b0;
      par_ok      <= 1'b0;
      to_cnt      <= '0;
      rx.rx_data  <= 8'h00;
      rx.rx_valid <= 1'b0;
      rx.rx_err   <= 1'b0;
      rx.overrun  <= 1'b0;
    end else begin
      state     <= state_n;
      sync1     <= ps2_data;
      sync2     <= sync1;
      clk_prev  <= ps2_clk_db;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      acc       <= acc_n;
      par_ok    <= par_ok_n;
      to_cnt    <= to_cnt_n;
      rx.rx_err <= frame_err;
      // An ack in the load cycle frees the slot, so the new byte replaces the old one.
      if (frame_good) begin
        if (!rx.rx_valid || rx.rx_ack) begin
          rx.rx_data  <= shreg;
          rx.rx_valid <= 1'b1;
          rx.overrun  <= 1'b0;
        end else begin
          rx.overrun  <= 1'b1;
        end
      end else if (rx.rx_valid && rx.rx_ack) begin
        rx.rx_valid <= 1'b0;
        rx.overrun  <= 1'b0;
      end
    end
  end

endmodule
